eth_tlp_extract: RTL
====================

Name: eth_tlp_extract

Overview:
Parametrised successor to the Eth/IP/UDP-to-TLP tap. Accepts AXI4-Stream Ethernet frames that carry an encapsulated TLP. Strips a fixed number of header beats and writes the TLP payload beats into the downstream TLP FIFO. Unlike its predecessor it applies real backpressure, drops whole packets when the FIFO lacks room at start-of-packet, and detects runt frames. Sits between the 10G MAC RX stream and the TLP injection FIFO.

Parameters:
C_DATA_WIDTH, 64, stream data width in bits; allowed values 64, 128, 256.
KEEP_WIDTH, C_DATA_WIDTH/32, dword-granular tkeep width.
HDR_BEATS, 6, leading beats per frame to discard (Eth+IP+UDP header padded by the sender to a beat boundary); range 1..15.
DIN_WIDTH, 4*KEEP_WIDTH+C_DATA_WIDTH+2, FIFO write-data width.

Ports:
user_clk  in  1  single clock domain for all logic.
user_reset  in  1  asynchronous, active-high reset.
s_axis_tdata  in  C_DATA_WIDTH  frame data.
s_axis_tkeep  in  KEEP_WIDTH  dword valid mask.
s_axis_tuser  in  1  error flag from the MAC, sampled per beat.
s_axis_tlast  in  1  end of frame.
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  beat accepted when tvalid && tready.
wr_en  out  1  FIFO write strobe.
din  out  DIN_WIDTH  {byte_keep, tdata, tlast, tuser}.
full  in  1  FIFO full.
prog_full  in  1  FIFO programmable full; threshold must leave room for one maximum TLP.
pkt_cnt  out  32  frames forwarded.
drop_cnt  out  32  frames dropped because prog_full was set at SOP.
runt_cnt  out  32  frames ending at or before the last header beat.

Behaviour:
- FSM states: IDLE, HDR, PAYLOAD, DROP. Reset (asynchronous, active-high) puts the FSM in IDLE, clears beat counter hdr_cnt and all counters. Outputs during and after reset: wr_en=0, s_axis_tready=0 while user_reset is high.
- IDLE: s_axis_tready=1. When an accepted beat arrives, it is the SOP and is always treated as header beat 0.
  - If prog_full=1 at that SOP: go to DROP, unless tlast is also set (then stay in IDLE). drop_cnt increments in either case.
  - Else if tlast=1: runt_cnt++, stay in IDLE.
  - Else: hdr_cnt=1, go to HDR; if HDR_BEATS==1, go directly to PAYLOAD.
- HDR: s_axis_tready=1. Each accepted beat increments hdr_cnt.
  - tlast on an accepted beat: runt_cnt++, go to IDLE.
  - hdr_cnt reaching HDR_BEATS: go to PAYLOAD.
- PAYLOAD: s_axis_tready = !full. wr_en = s_axis_tvalid && !full, combinational with zero latency. din is driven from the current input beat.
  - byte_keep = each tkeep bit replicated 4 times; MSB dword occupies the MSB keep bits.
  - Accepted beat with tlast: pkt_cnt++, go to IDLE.
- DROP: s_axis_tready=1, wr_en=0. Go to IDLE on the accepted tlast beat.
- wr_en is never 1 outside PAYLOAD. wr_en is never 1 while full=1.
- The drop decision is taken only at SOP. A prog_full change mid-packet has no effect.
- Counters wrap modulo 2^32.
- tuser is forwarded unchanged in din; it does not trigger a drop.
- The module holds no data storage, so reset mid-frame loses nothing internally. Upstream is reset by the same user_reset, so the first beat after reset is a true SOP.
- din is don't-care when wr_en=0; the bench must not check it then.

Optional Feature:
STATS_EN. When defined, pkt_cnt, drop_cnt and runt_cnt are implemented as described. When undefined, the counter registers are not built and all three ports are tied to 0; FSM behaviour is unchanged.

Test Plan:
- Reset then an 8-beat frame, HDR_BEATS=6, full=0, prog_full=0 -> exactly 2 wr_en pulses on beats 7 and 8; second din has tlast=1; pkt_cnt=1.
- Payload beat with tkeep=2'b01 at C_DATA_WIDTH=64 -> din byte_keep=8'h0F; tdata passes through bit-exact.
- full held high for 3 cycles mid-payload -> s_axis_tready=0 and wr_en=0 for those 3 cycles; beat stalled by the source is written once when full drops; no beat lost or duplicated.
- prog_full=1 at SOP of a 10-beat frame, then deasserted on beat 3 -> no wr_en for the whole frame; tready=1 throughout; drop_cnt=1; next frame forwarded normally.
- 4-beat frame with HDR_BEATS=6 -> no writes; runt_cnt=1; FSM in IDLE. A 1-beat frame gives the same result.
- user_reset asserted on payload beat 2 of a frame -> wr_en drops asynchronously to 0; counters read 0; next SOP is processed from IDLE.

Source files
------------

// File: rtl/eth_tlp_extract.sv
// rtl/eth_tlp_extract.sv - strips header beats from Ethernet frames and writes the TLP payload to a FIFO
// Optional STATS_EN builds pkt_cnt/drop_cnt/runt_cnt; otherwise those ports are tied to 0.
module eth_tlp_extract #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int HDR_BEATS    = 6,
  parameter int DIN_WIDTH    = 4 * KEEP_WIDTH + C_DATA_WIDTH + 2
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    wr_en,
  output logic [DIN_WIDTH-1:0]    din,
  input  logic                    full,
  input  logic                    prog_full,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             drop_cnt,
  output logic [31:0]             runt_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  localparam logic [3:0] HDR_LAST = 4'(HDR_BEATS);

  state_t                state_q, state_d;
  logic [3:0]            hdr_cnt_q, hdr_cnt_d;
  logic                  accept;
  logic [4*KEEP_WIDTH-1:0] byte_keep;

  // Ready and write strobe are gated by reset so they fall immediately, not at the next edge.
  assign s_axis_tready = !user_reset && ((state_q != PAYLOAD) || !full);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign wr_en         = !user_reset && (state_q == PAYLOAD) && s_axis_tvalid && !full;

  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_keep
    assign byte_keep[4*i +: 4] = {4{s_axis_tkeep[i]}};
  end

  assign din = {byte_keep, s_axis_tdata, s_axis_tlast, s_axis_tuser};

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q   <= IDLE;
      hdr_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (prog_full) begin
            if (!s_axis_tlast) state_d = DROP;
          end else if (!s_axis_tlast) begin
            hdr_cnt_d = 4'd1;
            state_d   = (HDR_BEATS == 1) ? PAYLOAD : HDR;
          end
        end
      end
      HDR: begin
        if (accept) begin
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (s_axis_tlast) begin
            hdr_cnt_d = 4'd0;
            state_d   = IDLE;
          end else if (hdr_cnt_q + 4'd1 == HDR_LAST) begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      DROP: begin
        if (accept && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STATS_EN
  logic        pkt_inc, drop_inc, runt_inc;
  logic [31:0] pkt_cnt_q, drop_cnt_q, runt_cnt_q;

  // A tlast on any header beat, including the last one, is a runt.
  assign pkt_inc  = accept && s_axis_tlast && (state_q == PAYLOAD);
  assign drop_inc = accept && (state_q == IDLE) && prog_full;
  assign runt_inc = accept && s_axis_tlast &&
                    (((state_q == IDLE) && !prog_full) || (state_q == HDR));

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 32'd0;
      runt_cnt_q <= 32'd0;
    end else begin
      if (pkt_inc)  pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (drop_inc) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (runt_inc) runt_cnt_q <= runt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign runt_cnt = runt_cnt_q;
`else
  assign pkt_cnt  = 32'd0;
  assign drop_cnt = 32'd0;
  assign runt_cnt = 32'd0;
`endif

endmodule
